// File: rtl/viterbi_frame_ctrl.sv
// ---------------------------------------------------------------------------
// viterbi_frame_ctrl
//
// Sequencer for the soft-decision Viterbi datapath. Collects one frame of
// NUM_SAMPLES sign-magnitude samples from an upstream valid/ready stream,
// holds them on r_bus, pulses dp_start, waits DP_LATENCY cycles, captures
// the decoded codeword and path metric, and offers them downstream with a
// valid/ready handshake.
//
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   in_valid/in_ready        upstream sample handshake
//   in_sample, in_last       sample value and end-of-frame marker
//   r_bus                    frame to datapath, r1 in the lowest slot
//   dp_start                 one-cycle datapath launch strobe
//   dp_codeword, dp_metric   datapath results
//   out_valid/out_ready      downstream result handshake
//   out_codeword, out_metric captured results
//   err_frame, err_clr       sticky framing error and its clear
//   frame_cnt                delivered-result counter (wraps)
//   busy                     high whenever not collecting samples
// ---------------------------------------------------------------------------
module viterbi_frame_ctrl #(
  parameter int SAMPLE_W    = 8,
  parameter int NUM_SAMPLES = 8,
  parameter int DP_LATENCY  = 2,   // legal range 1..15
  parameter int CW_W        = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SAMPLE_W-1:0]           in_sample,
  input  logic                          in_last,
  output logic [NUM_SAMPLES*SAMPLE_W-1:0] r_bus,
  output logic                          dp_start,
  input  logic [CW_W-1:0]               dp_codeword,
  input  logic [7:0]                    dp_metric,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CW_W-1:0]               out_codeword,
  output logic [7:0]                    out_metric,
  output logic                          err_frame,
  input  logic                          err_clr,
  output logic [15:0]                   frame_cnt,
  output logic                          busy
);

  localparam int IDX_W = $clog2(NUM_SAMPLES);
  localparam int CNT_W = 4;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_SAMPLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(DP_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_OUTPUT  = 2'd3
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   wait_cnt;

  // Handshake and status decode straight from the state register.
  assign in_ready = (state == ST_COLLECT);
  assign busy     = (state != ST_COLLECT);

  // NOTE: r_bus is a small flop bank, not a RAM, so it is cleared by reset
  // like every other register here; it is never cleared between frames.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= ST_COLLECT;
      idx          <= '0;
      wait_cnt     <= '0;
      r_bus        <= '0;
      dp_start     <= 1'b0;
      out_valid    <= 1'b0;
      out_codeword <= '0;
      out_metric   <= '0;
      err_frame    <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; the later err_frame <= 1
      // in COLLECT overrides this clear, giving a set priority over err_clr.
      dp_start <= 1'b0;
      if (err_clr) err_frame <= 1'b0;

      case (state)
        ST_COLLECT: begin
          if (in_valid) begin
            r_bus[idx*SAMPLE_W +: SAMPLE_W] <= in_sample;
            if (idx == LAST_IDX) begin
              idx <= '0;
              if (in_last) begin
                state    <= ST_LAUNCH;
                dp_start <= 1'b1;     // high for exactly the LAUNCH cycle
              end else begin
                err_frame <= 1'b1;    // frame overran without in_last
              end
            end else if (in_last) begin
              idx       <= '0;        // frame ended early
              err_frame <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end

        ST_LAUNCH: begin
          wait_cnt <= WAIT_LOAD;
          state    <= ST_WAIT;
        end

        ST_WAIT: begin
          if (wait_cnt == '0) begin
            out_codeword <= dp_codeword;
            out_metric   <= dp_metric;
            out_valid    <= 1'b1;
            state        <= ST_OUTPUT;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end

        ST_OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            frame_cnt <= frame_cnt + 16'd1;
            state     <= ST_COLLECT;
          end
        end

        default: state <= ST_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_viterbi_frame_ctrl
//
// Directed bench for viterbi_frame_ctrl. Instance dut uses the default
// DP_LATENCY=2; instance dut4 uses DP_LATENCY=4 for back-to-back framing and
// counter wrap. Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_viterbi_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst;

  // Default-latency instance signals
  logic        in_valid, in_ready, in_last, dp_start;
  logic [7:0]  in_sample, dp_codeword, dp_metric, out_codeword, out_metric;
  logic [63:0] r_bus;
  logic        out_valid, out_ready, err_frame, err_clr, busy;
  logic [15:0] frame_cnt;

  // DP_LATENCY=4 instance signals
  logic        in_valid4, in_ready4, in_last4, dp_start4;
  logic [7:0]  in_sample4, dp_codeword4, dp_metric4, out_codeword4, out_metric4;
  logic [63:0] r_bus4;
  logic        out_valid4, out_ready4, err_frame4, err_clr4, busy4;
  logic [15:0] frame_cnt4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  viterbi_frame_ctrl dut (
    .CLK(clk), .RST(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample), .in_last(in_last),
    .r_bus(r_bus), .dp_start(dp_start),
    .dp_codeword(dp_codeword), .dp_metric(dp_metric),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_codeword(out_codeword), .out_metric(out_metric),
    .err_frame(err_frame), .err_clr(err_clr),
    .frame_cnt(frame_cnt), .busy(busy)
  );

  viterbi_frame_ctrl #(.DP_LATENCY(4)) dut4 (
    .CLK(clk), .RST(rst),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_sample(in_sample4), .in_last(in_last4),
    .r_bus(r_bus4), .dp_start(dp_start4),
    .dp_codeword(dp_codeword4), .dp_metric(dp_metric4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_codeword(out_codeword4), .out_metric(out_metric4),
    .err_frame(err_frame4), .err_clr(err_clr4),
    .frame_cnt(frame_cnt4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Presents one sample for one cycle; returns on the falling edge after
  // the accepting rising edge.
  task automatic send(input logic [7:0] s, input logic last, input logic clr);
    in_valid  = 1'b1;
    in_sample = s;
    in_last   = last;
    err_clr   = clr;
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    err_clr   = 1'b0;
  endtask

  logic [7:0] fa [8] = '{8'h05, 8'h83, 8'h7F, 8'h00, 8'h81, 8'h10, 8'h22, 8'h90};
  logic [7:0] fb [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 0; in_sample = 0; in_last = 0; err_clr = 0; out_ready = 1;
    dp_codeword = 8'hB4; dp_metric = 8'h86;
    in_valid4 = 0; in_sample4 = 0; in_last4 = 0; err_clr4 = 0; out_ready4 = 1;
    dp_codeword4 = 8'h6D; dp_metric4 = 8'h8F;

    // ---- Reset state ----
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_r_bus", r_bus, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_err", err_frame, 0);
    check("rst_dp_start", dp_start, 0);
    rst = 1'b0;
    @(negedge clk);

    // ---- Good frame ----
    for (int i = 0; i < 8; i++) send(fa[i], i == 7, 1'b0);
    check("t1_r_bus", r_bus, 64'h90221081007F8305);
    check("t1_dp_start_hi", dp_start, 1);
    check("t1_in_ready_lo", in_ready, 0);
    check("t1_busy", busy, 1);
    @(negedge clk);
    check("t1_dp_start_lo", dp_start, 0);
    check("t1_valid_e2", out_valid, 0);
    @(negedge clk);
    check("t1_valid_e3", out_valid, 0);
    @(negedge clk);
    check("t1_valid_hi", out_valid, 1);
    check("t1_codeword", out_codeword, 8'hB4);
    check("t1_metric", out_metric, 8'h86);
    @(negedge clk);
    check("t1_valid_lo", out_valid, 0);
    check("t1_frame_cnt", frame_cnt, 1);
    check("t1_in_ready", in_ready, 1);

    // ---- Backpressure ----
    out_ready = 1'b0;
    dp_codeword = 8'h3C; dp_metric = 8'h07;
    for (int i = 0; i < 8; i++) send(fb[i], i == 7, 1'b0);
    check("t2_r_bus", r_bus, 64'h8877665544332211);
    repeat (3) @(negedge clk);
    check("t2_valid_hi", out_valid, 1);
    check("t2_codeword", out_codeword, 8'h3C);
    dp_codeword = 8'hFF; dp_metric = 8'hFF;   // must not be recaptured
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t2_hold_valid", out_valid, 1);
      check("t2_hold_cw", out_codeword, 8'h3C);
      check("t2_hold_metric", out_metric, 8'h07);
      check("t2_hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("t2_valid_lo", out_valid, 0);
    check("t2_frame_cnt", frame_cnt, 2);
    check("t2_in_ready", in_ready, 1);

    // ---- Early in_last on the 4th sample ----
    dp_codeword = 8'hA5; dp_metric = 8'h12;
    for (int i = 0; i < 4; i++) send(fb[i], i == 3, 1'b0);
    check("t3_err", err_frame, 1);
    check("t3_in_ready", in_ready, 1);
    check("t3_no_start", dp_start, 0);
    @(negedge clk);
    check("t3_no_start2", dp_start, 0);
    check("t3_frame_cnt", frame_cnt, 2);
    for (int i = 0; i < 8; i++) send(fa[i], i == 7, 1'b0);
    check("t3_r_bus", r_bus, 64'h90221081007F8305);
    check("t3_dp_start", dp_start, 1);
    repeat (3) @(negedge clk);
    check("t3_valid_hi", out_valid, 1);
    check("t3_codeword", out_codeword, 8'hA5);
    check("t3_metric", out_metric, 8'h12);
    @(negedge clk);
    check("t3_frame_cnt2", frame_cnt, 3);
    check("t3_err_sticky", err_frame, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t3_err_clr", err_frame, 0);

    // ---- Missing in_last on the 8th sample, err_clr in the same cycle ----
    for (int i = 0; i < 8; i++) send(fb[i], 1'b0, i == 7);
    check("t4_err_set_wins", err_frame, 1);
    check("t4_no_start", dp_start, 0);
    check("t4_in_ready", in_ready, 1);
    check("t4_busy", busy, 0);
    @(negedge clk);
    check("t4_frame_cnt", frame_cnt, 3);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t4_err_clr", err_frame, 0);

    // ---- Reset mid-WAIT ----
    dp_codeword = 8'hC3; dp_metric = 8'h81;
    for (int i = 0; i < 8; i++) send(fa[i], i == 7, 1'b0);
    @(negedge clk);
    check("t5_in_wait", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_in_ready", in_ready, 1);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_r_bus", r_bus, 0);
    check("t5_rst_frame_cnt", frame_cnt, 0);
    check("t5_rst_cw", out_codeword, 0);
    check("t5_rst_dp_start", dp_start, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t5_no_stale_valid", out_valid, 0);
      check("t5_ready_after", in_ready, 1);
    end

    // ---- Back-to-back frames, DP_LATENCY=4, counter wrap ----
    force dut4.frame_cnt = 16'hFFFE;
    @(negedge clk);
    release dut4.frame_cnt;
    @(negedge clk);
    check("t6_preload", frame_cnt4, 16'hFFFE);
    begin
      int   acc       = 0;
      int   rises     = 0;
      int   last_rise = 0;
      logic prev_v    = 1'b0;
      logic rdy;
      for (int cyc = 0; cyc < 100 && rises < 3; cyc++) begin
        in_valid4  = 1'b1;
        in_sample4 = 8'(acc);
        in_last4   = (acc % 8 == 7);
        rdy        = in_ready4;
        @(negedge clk);
        if (rdy) acc++;
        if (out_valid4 && !prev_v) begin
          rises++;
          check("t6_codeword", out_codeword4, 8'h6D);
          if (rises > 1) check("t6_period", 64'(cyc - last_rise), 14);
          if (rises == 2) check("t6_cnt_ffff", frame_cnt4, 16'hFFFF);
          if (rises == 3) check("t6_cnt_wrap", frame_cnt4, 16'h0000);
          last_rise = cyc;
        end
        prev_v = out_valid4;
      end
      in_valid4 = 1'b0;
      in_last4  = 1'b0;
      check("t6_rises", 64'(rises), 3);
      check("t6_no_err", err_frame4, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
